// File: rtl/timer_sequencer.sv
// Stopwatch/countdown timer control: set/run/pause/expired sequencing with an
// MM:SS datapath and press-and-hold auto-repeat for the adjust buttons.
module timer_sequencer #(
    parameter int unsigned MAX_MIN         = 59,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_1khz,
    input  logic       start,
    input  logic       stop,
    input  logic       soft_rst,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       inc_sw,
    input  logic       mode_sw,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       blink
);

    localparam int unsigned TW       = 6;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                       REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam logic [TW-1:0] MAX_M  = TW'(MAX_MIN);
    localparam logic [TW-1:0] MAX_S  = TW'(59);

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] min_q, min_d;
    logic [TW-1:0] sec_q, sec_d;
    logic          start_prev_q, stop_prev_q, imin_prev_q, isec_prev_q;
    logic [HW-1:0] hmin_cnt_q, hmin_cnt_d, hsec_cnt_q, hsec_cnt_d;
    logic          hmin_rep_q, hmin_rep_d, hsec_rep_q, hsec_rep_d;
    logic          running_q, expired_q;

    logic          start_e, stop_e, imin_e, isec_e;
    logic          adj_ok, is_zero, can_start;
    logic          min_rep_step, sec_rep_step, min_step, sec_step;

    // Hold-counter next value packed as {step, repeating, count}.
    function automatic logic [HW+1:0] hold_next(input logic [HW-1:0] cnt,
                                                input logic rep,
                                                input logic level,
                                                input logic en,
                                                input logic tick);
        logic [HW-1:0] nxt;
        logic [HW-1:0] lim;
        hold_next = {1'b0, rep, cnt};
        nxt       = cnt + HW'(1);
        lim       = rep ? HW'(REPEAT_RATE_MS) : HW'(REPEAT_DELAY_MS);
        if (!level || !en) begin
            hold_next = '0;
        end else if (tick) begin
            if (nxt == lim) hold_next = {1'b1, 1'b1, HW'(0)};
            else            hold_next = {1'b0, rep, nxt};
        end
    endfunction

    assign start_e   = start   & ~start_prev_q;
    assign stop_e    = stop    & ~stop_prev_q;
    assign imin_e    = inc_min & ~imin_prev_q;
    assign isec_e    = inc_sec & ~isec_prev_q;
    assign adj_ok    = (state_q == S_IDLE) || (state_q == S_PAUSE);
    assign is_zero   = (min_q == '0) && (sec_q == '0);
    assign can_start = mode_sw || !is_zero;
    assign min_step  = imin_e | min_rep_step;
    assign sec_step  = isec_e | sec_rep_step;

    // Auto-repeat counters for both adjust buttons.
    always_comb begin
        {min_rep_step, hmin_rep_d, hmin_cnt_d} =
            hold_next(hmin_cnt_q, hmin_rep_q, inc_min, adj_ok, tick_1khz);
        {sec_rep_step, hsec_rep_d, hsec_cnt_d} =
            hold_next(hsec_cnt_q, hsec_rep_q, inc_sec, adj_ok, tick_1khz);
    end

    // Next state and time, highest-priority event wins.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (soft_rst) begin
            state_d = S_IDLE;
            min_d   = '0;
            sec_d   = '0;
        end else if (stop_e && state_q == S_RUN) begin
            state_d = S_PAUSE;
        end else if (stop_e && state_q == S_EXPIRED) begin
            state_d = S_IDLE;
            min_d   = '0;
            sec_d   = '0;
        end else if (start_e && adj_ok && can_start) begin
            state_d = S_RUN;
        end else if (adj_ok && (min_step || sec_step)) begin
            if (min_step) begin
                if (inc_sw) min_d = (min_q == MAX_M) ? '0 : min_q + TW'(1);
                else        min_d = (min_q == '0) ? MAX_M : min_q - TW'(1);
            end
            if (sec_step) begin
                if (inc_sw) sec_d = (sec_q == MAX_S) ? '0 : sec_q + TW'(1);
                else        sec_d = (sec_q == '0) ? MAX_S : sec_q - TW'(1);
            end
        end else if (state_q == S_RUN && tick_1hz) begin
            if (mode_sw) begin
                if (min_q == MAX_M && sec_q == MAX_S) begin
                    state_d = S_EXPIRED;
                end else if (sec_q == MAX_S) begin
                    sec_d = '0;
                    min_d = min_q + TW'(1);
                end else begin
                    sec_d = sec_q + TW'(1);
                end
            end else begin
                // A direction flip at 00:00 has nothing left to count down.
                if (is_zero) begin
                    state_d = S_EXPIRED;
                end else begin
                    if (sec_q == '0) begin
                        sec_d = MAX_S;
                        min_d = min_q - TW'(1);
                    end else begin
                        sec_d = sec_q - TW'(1);
                    end
                    if (min_d == '0 && sec_d == '0) state_d = S_EXPIRED;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            min_q        <= '0;
            sec_q        <= '0;
            start_prev_q <= 1'b0;
            stop_prev_q  <= 1'b0;
            imin_prev_q  <= 1'b0;
            isec_prev_q  <= 1'b0;
            hmin_cnt_q   <= '0;
            hsec_cnt_q   <= '0;
            hmin_rep_q   <= 1'b0;
            hsec_rep_q   <= 1'b0;
            running_q    <= 1'b0;
            expired_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            start_prev_q <= start;
            stop_prev_q  <= stop;
            imin_prev_q  <= inc_min;
            isec_prev_q  <= inc_sec;
            hmin_cnt_q   <= hmin_cnt_d;
            hsec_cnt_q   <= hsec_cnt_d;
            hmin_rep_q   <= hmin_rep_d;
            hsec_rep_q   <= hsec_rep_d;
            running_q    <= (state_d == S_RUN);
            expired_q    <= (state_d == S_EXPIRED);
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign running = running_q;
    assign expired = expired_q;
    assign blink   = expired_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed self-checking bench for timer_sequencer.
module tb_timer_sequencer;

    logic       clk = 1'b0;
    logic       rst, tick_1hz, tick_1khz, start, stop, soft_rst;
    logic       inc_min, inc_sec, inc_sw, mode_sw;
    logic [5:0] minutes, seconds;
    logic       running, expired, blink;

    int checks   = 0;
    int failures = 0;

    timer_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_1khz (tick_1khz),
        .start     (start),
        .stop      (stop),
        .soft_rst  (soft_rst),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .inc_sw    (inc_sw),
        .mode_sw   (mode_sw),
        .minutes   (minutes),
        .seconds   (seconds),
        .running   (running),
        .expired   (expired),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mmss(input int m, input int s);
        return 32'(m * 100 + s);
    endfunction

    function automatic logic [31:0] now_t();
        return 32'(minutes) * 32'd100 + 32'(seconds);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start(); start = 1'b1; cyc(1); start = 1'b0; cyc(1); endtask
    task automatic press_stop();  stop = 1'b1;  cyc(1); stop = 1'b0;  cyc(1); endtask
    task automatic press_min();   inc_min = 1'b1; cyc(1); inc_min = 1'b0; cyc(1); endtask
    task automatic press_sec();   inc_sec = 1'b1; cyc(1); inc_sec = 1'b0; cyc(1); endtask
    task automatic pulse_1hz();   tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0; cyc(1); endtask
    task automatic pulse_1khz();  tick_1khz = 1'b1; cyc(1); tick_1khz = 1'b0; cyc(1); endtask
    task automatic soft_clear();  soft_rst = 1'b1; cyc(1); soft_rst = 1'b0; cyc(1); endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; tick_1khz = 1'b0; start = 1'b0; stop = 1'b0;
        soft_rst = 1'b0; inc_min = 1'b0; inc_sec = 1'b0; inc_sw = 1'b1; mode_sw = 1'b0;
        cyc(2);
        check_val("reset_time", now_t(), mmss(0, 0));
        check_val("reset_running", 32'(running), 32'd0);
        check_val("reset_expired", 32'(expired), 32'd0);
        rst = 1'b0;
        cyc(1);

        // Countdown from 02:03
        press_min(); press_min();
        press_sec(); press_sec(); press_sec();
        check_val("set_0203", now_t(), mmss(2, 3));
        start = 1'b1; tick_1hz = 1'b1; cyc(1); start = 1'b0; tick_1hz = 1'b0;
        check_val("start_running", 32'(running), 32'd1);
        check_val("start_tick_ignored", now_t(), mmss(2, 3));
        cyc(1);
        pulse_1hz();
        check_val("down_first", now_t(), mmss(2, 2));
        repeat (121) pulse_1hz();
        check_val("down_0001", now_t(), mmss(0, 1));
        check_val("down_not_expired", 32'(expired), 32'd0);
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
        check_val("down_zero", now_t(), mmss(0, 0));
        check_val("down_expired", 32'(expired), 32'd1);
        check_val("down_blink", 32'(blink), 32'd1);
        check_val("down_not_running", 32'(running), 32'd0);
        cyc(1);
        press_stop();
        check_val("ack_expired", 32'(expired), 32'd0);

        // Countdown start at 00:00 is ignored; decrement wraps seconds
        press_start();
        check_val("zero_start_ignored", 32'(running), 32'd0);
        inc_sw = 1'b0;
        press_sec();
        check_val("sec_wrap_down", now_t(), mmss(0, 59));
        soft_clear();
        check_val("soft_rst_clear", now_t(), mmss(0, 0));

        // Auto-repeat on held inc_sec
        inc_sw = 1'b1;
        inc_sec = 1'b1; cyc(1);
        check_val("hold_first_step", now_t(), mmss(0, 1));
        repeat (499) pulse_1khz();
        check_val("hold_before_delay", now_t(), mmss(0, 1));
        pulse_1khz();
        check_val("hold_at_delay", now_t(), mmss(0, 2));
        repeat (99) pulse_1khz();
        check_val("hold_before_rate", now_t(), mmss(0, 2));
        repeat (651) pulse_1khz();
        check_val("hold_1250", now_t(), mmss(0, 9));
        inc_sec = 1'b0; cyc(1);
        repeat (600) pulse_1khz();
        check_val("hold_released", now_t(), mmss(0, 9));
        soft_clear();

        // Stop edge beats a simultaneous tick
        mode_sw = 1'b1; inc_sw = 1'b0;
        press_sec();
        press_start();
        check_val("up_running", 32'(running), 32'd1);
        stop = 1'b1; tick_1hz = 1'b1; cyc(1); stop = 1'b0; tick_1hz = 1'b0;
        check_val("stop_pause", 32'(running), 32'd0);
        check_val("stop_beats_tick", now_t(), mmss(0, 59));
        cyc(1);
        press_start();
        pulse_1hz();
        check_val("up_carry", now_t(), mmss(1, 0));
        mode_sw = 1'b0;
        pulse_1hz();
        check_val("dir_reverse", now_t(), mmss(0, 59));
        press_stop();
        soft_clear();

        // Count up saturates at 59:59 and expires
        mode_sw = 1'b1; inc_sw = 1'b0;
        press_min(); press_sec();
        check_val("preset_5959", now_t(), mmss(59, 59));
        press_start();
        pulse_1hz();
        check_val("up_hold_max", now_t(), mmss(59, 59));
        check_val("up_expired", 32'(expired), 32'd1);
        press_start();
        pulse_1hz();
        check_val("expired_frozen", now_t(), mmss(59, 59));
        press_stop();
        check_val("expired_ack_time", now_t(), mmss(0, 0));
        check_val("expired_ack_blink", 32'(blink), 32'd0);

        // Synchronous reset mid-run at 12:34
        inc_sw = 1'b1;
        repeat (12) press_min();
        repeat (34) press_sec();
        check_val("preset_1234", now_t(), mmss(12, 34));
        press_start();
        pulse_1hz();
        check_val("run_1235", now_t(), mmss(12, 35));
        rst = 1'b1; cyc(2); rst = 1'b0;
        check_val("rst_mid_time", now_t(), mmss(0, 0));
        check_val("rst_mid_running", 32'(running), 32'd0);
        check_val("rst_mid_blink", 32'(blink), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
